mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- RAM-side responder for the data cache's write-through/refill port.
- Accepts one 32-bit word request (read or byte-masked write) at a time.
- Serializes each request onto an 8-bit external SRAM, then pulses `ram_data_ready` for one cycle on completion.
- Sits between the cache's RAM port and the board memory pins.

Parameters:
- WAIT_CYCLES, 2: cycles each byte access is held on the external bus; legal range is 1 or more.
- ADDR_WIDTH, 17: external byte-address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ram_addr_i  in  32  request byte address; bits [1:0] are ignored (word-aligned).
- ram_we_i  in  1  1 = write, 0 = read.
- ram_sel_i  in  4  byte enables for writes; bit k selects data[8k+7:8k].
- ram_data_i  in  32  write data.
- ram_ce_i  in  1  request valid.
- ram_data_o  out  32  read data.
- ram_data_ready  out  1  one-cycle completion pulse.
- busy_o  out  1  high while a request is in flight.
- ext_addr_o  out  ADDR_WIDTH  external byte address.
- ext_data_o  out  8  external write byte.
- ext_data_i  in  8  external read byte; valid on the last cycle of each slot.
- ext_ce_o  out  1  external chip enable.
- ext_we_o  out  1  external write enable.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs forced to 0;
  - state = IDLE; byte index, wait counter and latched request cleared.
- States: IDLE, XFER, DONE.
- IDLE:
  - busy_o=0, ext_ce_o=0.
  - If ram_ce_i=1 at a rising edge, latch addr/we/sel/data.
  - Read: go to XFER at byte 0.
  - Write: go to XFER at the lowest selected byte; if sel=0, go directly to DONE.
- XFER:
  - busy_o=1.
  - Byte slot k drives ext_addr_o={addr[ADDR_WIDTH-1:2], k[1:0]} and ext_ce_o=1 for exactly WAIT_CYCLES cycles.
  - Writes: ext_we_o=1 and ext_data_o=latched data[8k+7:8k] for the whole slot.
  - Reads: ext_we_o=0; ext_data_i is captured into buffer byte k at the rising edge ending the slot.
  - Reads visit bytes 0..3 in order. Writes visit only selected bytes in ascending order; unselected bytes cost 0 cycles.
  - After the last slot, go to DONE.
- DONE:
  - ram_data_ready=1 for exactly one cycle; ext_ce_o=0; busy_o=1.
  - Reads: ram_data_o = assembled word, little-endian (byte 0 in [7:0]).
  - Next state is IDLE. A request still asserted is re-accepted only from IDLE, so there is a minimum 1-cycle gap between completions.
- ram_data_o holds the last read word until the next read reaches DONE; writes never change it.
- Latency (request cycle = 0):
  - read: data_ready in cycle 4*WAIT_CYCLES+1;
  - write: data_ready in cycle popcount(sel)*WAIT_CYCLES+1.
- Inputs are ignored after the latch: changing or dropping ram_ce_i mid-transaction does not abort. The transaction completes and data_ready still pulses, so a write-through is never torn.
- Reset mid-transaction: immediate abort, no data_ready. A partially written word is permitted and is not rolled back.
- ext_addr_o and ext_data_o are 0 whenever ext_ce_o=0.

Optional Feature:
- Macro: MEM_CTRL_READ_BUFFER_EN.
- Defined: a one-entry buffer holds {valid, word address, data} of the last completed read.
  - A read hitting a valid entry skips XFER: IDLE→DONE, data_ready in cycle 1, no ext_ce_o activity.
  - Any accepted write to the same word address clears valid; reset clears valid.
- Undefined: no buffer; every read performs 4 external slots.

Test Plan:
- Reset: hold rst=0 with ram_ce_i=1 → all outputs 0, no ext_ce_o. Release → IDLE, then accept begins on the next edge.
- Read: ext bytes 0x100..0x103 = 11,22,33,44; read addr 0x00000100 → ext_addr 0x100,0x101,0x102,0x103 for 2 cycles each; data_ready only in cycle 9; ram_data_o=0x44332211.
- Masked write: addr 0x204, sel=4'b0101, data 0xAABBCCDD → writes 0xDD@0x204, then 0xBB@0x206; 4 ext_ce_o cycles; data_ready in cycle 5. A subsequent read shows bytes 0x205/0x207 unchanged.
- Empty write: sel=0 → no ext_ce_o; data_ready in cycle 1; ram_data_o unchanged.
- Robustness:
  - drop ram_ce_i at cycle 3 of a read → read still completes, data_ready at cycle 9;
  - assert rst at cycle 3 of a write with sel=4'b1111 → outputs 0 immediately, no data_ready, state IDLE.
- MEM_CTRL_READ_BUFFER_EN defined:
  - read 0x100 twice → second completes in cycle 1 with no ext activity, data 0x44332211;
  - write 0x100 sel=4'b0001 data 0x99, then read → full 9-cycle read returning 0x44332299.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes one 32-bit cache RAM request at a time onto an 8-bit external SRAM.
// Define MEM_CTRL_READ_BUFFER_EN to add a one-entry buffer that answers repeated reads without bus activity.
module mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ram_addr_i,
  input  logic                  ram_we_i,
  input  logic [3:0]            ram_sel_i,
  input  logic [31:0]           ram_data_i,
  input  logic                  ram_ce_i,
  output logic [31:0]           ram_data_o,
  output logic                  ram_data_ready,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] ext_addr_o,
  output logic [7:0]            ext_data_o,
  input  logic [7:0]            ext_data_i,
  output logic                  ext_ce_o,
  output logic                  ext_we_o
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYCLES - 1);
  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_we, w_we_nxt;
  logic [3:0]      r_sel, w_sel_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic [1:0]      r_byte, w_byte_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic [31:0]     r_rbuf, w_rbuf_nxt;
  logic [2:0]      w_scan;
  logic            w_hit;
  logic [31:0]     w_hit_data;

  logic [31:0]           r_data_o, w_data_o_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [ADDR_WIDTH-1:0] r_ext_addr, w_ext_addr_nxt;
  logic [7:0]            r_ext_data, w_ext_data_nxt;
  logic                  r_ext_ce, w_ext_ce_nxt;
  logic                  r_ext_we, w_ext_we_nxt;

  logic w_unused_addr;
  assign w_unused_addr = ^{ram_addr_i[31:ADDR_WIDTH], ram_addr_i[1:0]};

  // Returns {found, index} of the lowest enabled byte at or above 'from'.
  function automatic logic [2:0] f_next_byte(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

`ifdef MEM_CTRL_READ_BUFFER_EN
  logic          r_rb_valid;
  logic [AW-1:0] r_rb_addr;
  logic [31:0]   r_rb_data;

  assign w_hit      = r_rb_valid && !ram_we_i && (ram_addr_i[ADDR_WIDTH-1:2] == r_rb_addr);
  assign w_hit_data = r_rb_data;

  // Read buffer: filled by every external read, invalidated by any write to its word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rb_valid <= 1'b0;
      r_rb_addr  <= {AW{1'b0}};
      r_rb_data  <= 32'h0;
    end else if (r_state == S_IDLE && ram_ce_i && ram_we_i &&
                 ram_addr_i[ADDR_WIDTH-1:2] == r_rb_addr) begin
      r_rb_valid <= 1'b0;
    end else if (r_state == S_XFER && w_state_nxt == S_DONE && !r_we) begin
      r_rb_valid <= 1'b1;
      r_rb_addr  <= r_addr;
      r_rb_data  <= w_rbuf_nxt;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'h0;
`endif

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= {AW{1'b0}};
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_wdata <= 32'h0;
      r_byte  <= 2'd0;
      r_wait  <= {WW{1'b0}};
      r_rbuf  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_wdata <= w_wdata_nxt;
      r_byte  <= w_byte_nxt;
      r_wait  <= w_wait_nxt;
      r_rbuf  <= w_rbuf_nxt;
    end
  end

  // Next-state logic: request latch, slot timing and byte sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_wdata_nxt = r_wdata;
    w_byte_nxt  = r_byte;
    w_wait_nxt  = r_wait;
    w_rbuf_nxt  = r_rbuf;
    w_scan      = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (ram_ce_i) begin
          w_addr_nxt  = ram_addr_i[ADDR_WIDTH-1:2];
          w_we_nxt    = ram_we_i;
          w_sel_nxt   = ram_sel_i;
          w_wdata_nxt = ram_data_i;
          w_wait_nxt  = {WW{1'b0}};
          w_scan      = f_next_byte(ram_we_i ? ram_sel_i : 4'b1111, 3'd0);
          w_byte_nxt  = w_scan[1:0];
          if (w_hit || !w_scan[2]) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_XFER;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_XFER: begin
        if (r_wait == LAST_WAIT) begin
          w_wait_nxt = {WW{1'b0}};
          if (!r_we) begin
            w_rbuf_nxt[{r_byte, 3'b000} +: 8] = ext_data_i;
          end else begin
            w_rbuf_nxt = r_rbuf;
          end
          w_scan = f_next_byte(r_we ? r_sel : 4'b1111, {1'b0, r_byte} + 3'd1);
          if (w_scan[2]) begin
            w_byte_nxt = w_scan[1:0];
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_wait_nxt = r_wait + {{(WW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    w_ext_ce_nxt = (w_state_nxt == S_XFER);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_ready_nxt  = (w_state_nxt == S_DONE);
    if (w_ext_ce_nxt) begin
      w_ext_addr_nxt = {w_addr_nxt, w_byte_nxt};
      w_ext_we_nxt   = w_we_nxt;
      w_ext_data_nxt = w_we_nxt ? w_wdata_nxt[{w_byte_nxt, 3'b000} +: 8] : 8'h00;
    end else begin
      w_ext_addr_nxt = {ADDR_WIDTH{1'b0}};
      w_ext_we_nxt   = 1'b0;
      w_ext_data_nxt = 8'h00;
    end
    if (w_state_nxt == S_DONE && r_state != S_DONE && !w_we_nxt) begin
      w_data_o_nxt = (r_state == S_IDLE) ? w_hit_data : w_rbuf_nxt;
    end else begin
      w_data_o_nxt = r_data_o;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_o   <= 32'h0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_ext_addr <= {ADDR_WIDTH{1'b0}};
      r_ext_data <= 8'h00;
      r_ext_ce   <= 1'b0;
      r_ext_we   <= 1'b0;
    end else begin
      r_data_o   <= w_data_o_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_ext_addr <= w_ext_addr_nxt;
      r_ext_data <= w_ext_data_nxt;
      r_ext_ce   <= w_ext_ce_nxt;
      r_ext_we   <= w_ext_we_nxt;
    end
  end

  assign ram_data_o     = r_data_o;
  assign ram_data_ready = r_ready;
  assign busy_o         = r_busy;
  assign ext_addr_o     = r_ext_addr;
  assign ext_data_o     = r_ext_data;
  assign ext_ce_o       = r_ext_ce;
  assign ext_we_o       = r_ext_we;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random requests against a word-level memory model with an external SRAM.
module tb_mem_ctrl;
  localparam int W     = 2;
  localparam int AW    = 17;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   ram_addr_i = 32'h0;
  logic          ram_we_i = 1'b0;
  logic [3:0]    ram_sel_i = 4'h0;
  logic [31:0]   ram_data_i = 32'h0;
  logic          ram_ce_i = 1'b0;
  logic [31:0]   ram_data_o;
  logic          ram_data_ready;
  logic          busy_o;
  logic [AW-1:0] ext_addr_o;
  logic [7:0]    ext_data_o;
  logic [7:0]    ext_data_i;
  logic          ext_ce_o;
  logic          ext_we_o;

  logic [7:0]    sram    [0:MEMSZ-1];
  logic [7:0]    ref_mem [0:MEMSZ-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = 17'h0;
  logic [7:0]    pre_data = 8'h00;

  int            total = 0;
  int            bad = 0;
  logic [31:0]   last_read = 32'h0;
  logic          buf_valid = 1'b0;
  logic [AW-3:0] buf_addr = 15'h0;

  mem_ctrl #(.WAIT_CYCLES(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ram_addr_i(ram_addr_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_data_i(ram_data_i), .ram_ce_i(ram_ce_i),
    .ram_data_o(ram_data_o), .ram_data_ready(ram_data_ready), .busy_o(busy_o),
    .ext_addr_o(ext_addr_o), .ext_data_o(ext_data_o), .ext_data_i(ext_data_i),
    .ext_ce_o(ext_ce_o), .ext_we_o(ext_we_o)
  );

  always #5 clk = ~clk;

  assign ext_data_i = sram[ext_addr_o];

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (ext_ce_o && ext_we_o) sram[ext_addr_o] <= ext_data_o;
  end

  function automatic logic [31:0] ref_word(input logic [AW-3:0] wa);
    return {ref_mem[{wa, 2'd3}], ref_mem[{wa, 2'd2}], ref_mem[{wa, 2'd1}], ref_mem[{wa, 2'd0}]};
  endfunction

  function automatic bit outs_zero();
    return (ram_data_o == 32'h0) && !ram_data_ready && !busy_o && (ext_addr_o == 17'h0) &&
           (ext_data_o == 8'h00) && !ext_ce_o && !ext_we_o;
  endfunction

  // One request; expectations come from the word model, not the DUT.
  task automatic do_txn(input string name, input logic [31:0] addr, input logic we,
                        input logic [3:0] sel, input logic [31:0] data, input int hold);
    logic [AW-3:0] wa;
    logic          hit;
    logic [25:0]   exp_q[$];
    logic [25:0]   obs_q[$];
    int            exp_rdy, rdy_cnt, rdy_cyc, busy_cnt, zero_bad, first_bad;
    wa = addr[AW-1:2];
    hit = 1'b0;
`ifdef MEM_CTRL_READ_BUFFER_EN
    hit = !we && buf_valid && (buf_addr == wa);
`endif
    if (!hit) begin
      for (int k = 0; k < 4; k++)
        if (!we || sel[k])
          for (int r = 0; r < W; r++) exp_q.push_back({we, wa, 2'(k), we ? data[8*k +: 8] : 8'h00});
    end
    exp_rdy = 1 + exp_q.size();
    if (we) begin
      for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[{wa, 2'(k)}] = data[8*k +: 8];
      if (wa == buf_addr) buf_valid = 1'b0;
    end else begin
      last_read = ref_word(wa);
      buf_valid = 1'b1;
      buf_addr  = wa;
    end

    @(negedge clk);
    ram_addr_i = addr; ram_we_i = we; ram_sel_i = sel; ram_data_i = data; ram_ce_i = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) ram_ce_i = 1'b0;
    ram_addr_i = $urandom; ram_we_i = 1'($urandom); ram_sel_i = 4'($urandom); ram_data_i = $urandom;
    rdy_cnt = 0; rdy_cyc = 0; busy_cnt = 0; zero_bad = 0;
    for (int n = 1; n <= exp_rdy + 2; n++) begin
      @(negedge clk);
      if (ram_data_ready) begin rdy_cnt++; rdy_cyc = n; end
      if (busy_o) busy_cnt++;
      if (ext_ce_o) obs_q.push_back({ext_we_o, ext_addr_o, ext_we_o ? ext_data_o : 8'h00});
      else if (ext_addr_o != 17'h0 || ext_data_o != 8'h00) zero_bad++;
      if (n == hold) ram_ce_i = 1'b0;
    end

    total++;
    if (rdy_cnt !== 1 || rdy_cyc !== exp_rdy) begin
      bad++;
      $display("FAIL %s ready: cycle=%0d pulses=%0d, want cycle=%0d pulses=1", name, rdy_cyc, rdy_cnt, exp_rdy);
    end
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (first_bad < 0 && obs_q[i] !== exp_q[i]) first_bad = i;
    total++;
    if (obs_q.size() != exp_q.size() || first_bad >= 0) begin
      bad++;
      $display("FAIL %s ext_trace: got %0d slots-cycles (first diff %0d: %h), want %0d (%h)", name,
               obs_q.size(), first_bad, (first_bad >= 0) ? obs_q[first_bad] : 26'h0,
               exp_q.size(), (first_bad >= 0) ? exp_q[first_bad] : 26'h0);
    end
    total++;
    if (busy_cnt !== exp_rdy) begin
      bad++;
      $display("FAIL %s busy: got %0d cycles, want %0d", name, busy_cnt, exp_rdy);
    end
    total++;
    if (zero_bad !== 0) begin
      bad++;
      $display("FAIL %s idle_bus: %0d cycles with nonzero addr/data while ce=0, want 0", name, zero_bad);
    end
    total++;
    if (ram_data_o !== last_read) begin
      bad++;
      $display("FAIL %s data_o: got %h, want %h", name, ram_data_o, last_read);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[17'h100] = 8'h11; ref_mem[17'h101] = 8'h22;
    ref_mem[17'h102] = 8'h33; ref_mem[17'h103] = 8'h44;
    ref_mem[17'h204] = 8'h01; ref_mem[17'h205] = 8'h02;
    ref_mem[17'h206] = 8'h03; ref_mem[17'h207] = 8'h04;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 17'(i); pre_data = ref_mem[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    int zb;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h0000_0100; ram_sel_i = 4'hf;
    zb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!outs_zero()) zb++;
    end
    total++;
    if (zb !== 0) begin
      bad++;
      $display("FAIL reset_outputs: %0d cycles with nonzero outputs, want 0", zb);
    end
    rst = 1'b1;
    last_read = ref_word(15'h40); buf_valid = 1'b1; buf_addr = 15'h40;
    @(negedge clk);
    ram_ce_i = 1'b0;
    total++;
    if (!busy_o || !ext_ce_o || ext_addr_o !== 17'h100 || ram_data_ready) begin
      bad++;
      $display("FAIL reset_accept: busy=%b ce=%b addr=%h rdy=%b, want 1 1 100 0",
               busy_o, ext_ce_o, ext_addr_o, ram_data_ready);
    end
    repeat (4 * W + 2) @(negedge clk);
    total++;
    if (ram_data_o !== last_read) begin
      bad++;
      $display("FAIL reset_first_read: got %h, want %h", ram_data_o, last_read);
    end
  endtask

  task automatic test_read();
    do_txn("read_100", 32'h0000_0100, 1'b0, 4'h0, 32'h0, 0);
    do_txn("read_104_hiaddr", 32'hFFFE_0107, 1'b0, 4'h0, 32'h0, 0);
  endtask

  task automatic test_masked_write();
    do_txn("wr_204_0101", 32'h0000_0204, 1'b1, 4'b0101, 32'hAABB_CCDD, 0);
    do_txn("rd_204_after_wr", 32'h0000_0204, 1'b0, 4'h0, 32'h0, 0);
  endtask

  task automatic test_empty_write();
    do_txn("wr_empty", 32'h0000_0208, 1'b1, 4'b0000, 32'h1234_5678, 0);
  endtask

  task automatic test_drop_ce();
    do_txn("rd_drop_ce", 32'h0000_0104, 1'b0, 4'h0, 32'h0, 3);
  endtask

  task automatic test_reset_abort();
    int rdy, zb;
    @(negedge clk);
    ram_addr_i = 32'h0000_03F0; ram_we_i = 1'b1; ram_sel_i = 4'hf; ram_data_i = $urandom; ram_ce_i = 1'b1;
    @(posedge clk);
    #1 ram_ce_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    buf_valid = 1'b0; last_read = 32'h0;
    total++;
    if (!outs_zero()) begin
      bad++;
      $display("FAIL abort_immediate: busy=%b ce=%b rdy=%b data_o=%h, want all 0",
               busy_o, ext_ce_o, ram_data_ready, ram_data_o);
    end
    rdy = 0; zb = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram_data_ready) rdy++;
      if (!outs_zero()) zb++;
    end
    rst = 1'b1;
    total++;
    if (rdy !== 0 || zb !== 0) begin
      bad++;
      $display("FAIL abort_hold: ready pulses=%0d nonzero cycles=%0d, want 0 0", rdy, zb);
    end
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: busy=%b, want 0", busy_o);
    end
    do_txn("abort_restore", 32'h0000_03F0, 1'b1, 4'hf, $urandom, 0);
    do_txn("abort_readback", 32'h0000_03F0, 1'b0, 4'h0, 32'h0, 0);
  endtask

  task automatic test_repeat_read();
    do_txn("rr_first", 32'h0000_0100, 1'b0, 4'h0, 32'h0, 0);
    do_txn("rr_second", 32'h0000_0100, 1'b0, 4'h0, 32'h0, 0);
    do_txn("rr_write", 32'h0000_0100, 1'b1, 4'b0001, 32'h0000_0099, 0);
    do_txn("rr_after_wr", 32'h0000_0100, 1'b0, 4'h0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr, prev;
    prev = 32'h0000_0100;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      addr[16:10] = 7'h00;
      if ($urandom_range(0, 3) == 0) addr = prev;
      do_txn("random", addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 0);
      prev = addr;
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_read();
    test_masked_write();
    test_empty_write();
    test_drop_ce();
    test_reset_abort();
    test_repeat_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
